cuenta_bits_param: RTL and testbench
====================================

Name: cuenta_bits_param

Overview:
Parametrised serial bit-timing counter for the PS/2 and SPI transmit paths.
- Divides clk by a runtime divisor into bit ticks and counts a runtime number of bits.
- Asserts `tiempo` for one cycle when the frame completes; supports abort.
- Feeds the shift-register and frame FSMs of the controllers.

Parameters:
- CNT_W, 5, width of bit counter and n_bits port (max frame 2^CNT_W-1 bits)
- DIV_W, 16, width of prescaler and div port

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin frame; sampled only in IDLE
- abort  in  1  cancel frame; highest priority after rst
- n_bits  in  CNT_W  bits per frame, latched on accepted start
- div  in  DIV_W  clk cycles per bit, latched on accepted start; 0 treated as 1
- busy  out  1  high in RUN
- tick  out  1  one-cycle bit-boundary strobe
- bit_idx  out  CNT_W  bits completed so far in the current frame
- tiempo  out  1  one-cycle frame-done pulse
- mid  out  1  mid-bit strobe (CB_MID_TICK_EN only)

Behaviour:
- Single clock; reset is synchronous and active-high. The clock port is `clk`, the reset port is `rst`.
- Reset values: state=IDLE, pre=0, bit_idx=0, n_q=0, div_q=1; busy, tick, tiempo and mid all 0.
- States:
  - IDLE: start=1 → latch n_q and div_q (0→1), clear pre and bit_idx. Go to RUN if n_bits≠0, otherwise go straight to DONE.
  - RUN: pre increments each cycle. At pre==div_q-1: tick=1 (combinational from registered state), pre→0, bit_idx+1. If that tick completes bit n_q (bit_idx==n_q-1), go to DONE.
  - DONE: tiempo=1 for exactly one cycle, then IDLE. bit_idx holds n_q until the next accepted start.
- Latency, counting the start-sampling edge as cycle 0:
  - first tick in cycle div_q
  - k-th tick in cycle k·div_q
  - tiempo in cycle n_q·div_q+1
  - n_bits=0 → tiempo in cycle 1 with no tick
- div_q=1 → tick every RUN cycle.
- start while in RUN or DONE is ignored; no queuing.
- A new start in the same cycle that tiempo is high is ignored. The next start is accepted in IDLE.
- abort=1 in RUN or DONE → IDLE at the next edge:
  - no tiempo, even if abort coincides with the final tick
  - busy falls, pre=0
  - bit_idx is left frozen
- abort in IDLE has no effect. abort together with start in IDLE: abort wins and start is dropped.
- rst overrides everything, including mid-frame.
- Changes on n_bits and div after start is accepted have no effect on the current frame.
- Counters never wrap inside a frame. bit_idx ≤ n_q ≤ 2^CNT_W-1.

Optional Feature:
- Macro: CB_MID_TICK_EN.
- Defined: port `mid` exists. mid=1 in RUN when pre==(div_q-1)>>1 (div_q=4 → pre==1; div_q=1 → coincides with tick). This is the sample strobe for SPI and PS/2 receive.
- Undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Package cuenta_bits_pkg:
  - state enum {IDLE, RUN, DONE}, 2-bit encoding
  - default CNT_W and DIV_W localparams
  - DIV_MIN=1 constant
- Sub-module divisor_tick (parameter DIV_W): inputs clk, rst, clr, en, div_q; outputs tick and, under the macro, mid. Owns the prescaler register.
- The top level owns the FSM, bit counter and latches.

Test Plan:
- rst high 2 cycles mid-run → busy=0, bit_idx=0, tiempo=0 on the next cycle; the frame never completes.
- start, n_bits=8, div=4 → ticks in cycles 4,8,…,32; tiempo only in cycle 33; bit_idx=8 afterwards; busy high cycles 1–32.
- start, n_bits=11, div=0 → behaves as div=1: 11 consecutive ticks (cycles 1–11), tiempo in cycle 12.
- n_bits=0 start → tiempo in cycle 1, no tick, busy never high.
- n_bits=8, div=4, abort in cycle 14 → IDLE in cycle 15, bit_idx frozen at 3, no tiempo. A second start in cycle 14 is ignored.
- CB_MID_TICK_EN, div=4, n_bits=2 → mid in cycles 2 and 6; with the macro undefined, tick timing is unchanged (regression).

Source files
------------

// File: rtl/cuenta_bits_pkg.sv
// Shared types and defaults for the serial bit-timing counter.
// Build option CB_MID_TICK_EN adds the mid-bit strobe.
package cuenta_bits_pkg;

    localparam int CNT_W_DEF = 5;
    localparam int DIV_W_DEF = 16;
    localparam int DIV_MIN   = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/cuenta_bits_param_if.sv
// Control and status bundle of the bit-timing counter.
// The mid signal exists only when CB_MID_TICK_EN is defined.
interface cuenta_bits_param_if
    import cuenta_bits_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int DIV_W = DIV_W_DEF
);
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] n_bits;
    logic [DIV_W-1:0] div;
    logic             busy;
    logic             tick;
    logic [CNT_W-1:0] bit_idx;
    logic             tiempo;
`ifdef CB_MID_TICK_EN
    logic             mid;
`endif

    modport master (
        output start, abort, n_bits, div,
        input  busy, tick, bit_idx, tiempo
`ifdef CB_MID_TICK_EN
        , input mid
`endif
    );

    modport slave (
        input  start, abort, n_bits, div,
        output busy, tick, bit_idx, tiempo
`ifdef CB_MID_TICK_EN
        , output mid
`endif
    );
endinterface

// File: rtl/divisor_tick.sv
// Prescaler: tick when pre reaches div_q-1 (combinational from pre_q), mid at the bit centre
// when CB_MID_TICK_EN is defined; clr forces pre to zero, no backpressure.
module divisor_tick
    import cuenta_bits_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [DIV_W-1:0] div_q,
    output logic             tick
`ifdef CB_MID_TICK_EN
    , output logic           mid
`endif
);
    logic [DIV_W-1:0] pre_q, pre_d;
    logic [DIV_W-1:0] last;

    // div_q is never zero, so last cannot underflow
    assign last = div_q - DIV_W'(DIV_MIN);
    assign tick = en && (pre_q == last);

`ifdef CB_MID_TICK_EN
    assign mid = en && (pre_q == (last >> 1));
`endif

    always_comb begin
        pre_d = pre_q;
        if (clr) begin
            pre_d = '0;
        end else if (en) begin
            pre_d = tick ? '0 : pre_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end
endmodule

// File: rtl/cuenta_bits_param.sv
// Serial bit-timing counter: n_bits ticks of div clocks each, then a one-cycle tiempo pulse.
// First tick div_q cycles after start, tiempo one cycle after the last tick; start ignored unless IDLE.
module cuenta_bits_param
    import cuenta_bits_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    cuenta_bits_param_if.slave bus
);
    state_e           state_q, state_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic [CNT_W-1:0] bit_idx_q, bit_idx_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             tick;
    logic             run;

    assign run = (state_q == RUN);

    divisor_tick #(.DIV_W(DIV_W)) u_divisor_tick (
        .clk   (clk),
        .rst   (rst),
        .clr   (bus.abort || !run),
        .en    (run),
        .div_q (div_q),
        .tick  (tick)
`ifdef CB_MID_TICK_EN
        , .mid (bus.mid)
`endif
    );

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        div_d     = div_q;
        bit_idx_d = bit_idx_q;
        case (state_q)
            IDLE: begin
                // abort in IDLE swallows a coincident start
                if (bus.start && !bus.abort) begin
                    n_d       = bus.n_bits;
                    div_d     = (bus.div == '0) ? DIV_W'(DIV_MIN) : bus.div;
                    bit_idx_d = '0;
                    state_d   = (bus.n_bits != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (tick) begin
                    bit_idx_d = bit_idx_q + CNT_W'(1);
                    if (bit_idx_q == n_q - CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            n_q       <= '0;
            div_q     <= DIV_W'(DIV_MIN);
            bit_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            div_q     <= div_d;
            bit_idx_q <= bit_idx_d;
        end
    end

    assign bus.busy    = run;
    assign bus.tick    = tick;
    assign bus.bit_idx = bit_idx_q;
    assign bus.tiempo  = (state_q == DONE);
endmodule

// File: tb/tb_cuenta_bits_param.sv
// Scoreboard bench: each accepted start schedules its tick/tiempo/mid events by cycle number;
// a negedge monitor pops and compares whenever the DUT strobes.
module tb_cuenta_bits_param;
    localparam int CNT_W = 5;
    localparam int DIV_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cuenta_bits_param_if #(.CNT_W(CNT_W), .DIV_W(DIV_W)) bus ();
    cuenta_bits_param #(.CNT_W(CNT_W), .DIV_W(DIV_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        int cyc;
        int idx;
    } ev_t;

    ev_t tick_q[$];
    ev_t tiempo_q[$];
    ev_t mid_q[$];

    int checks    = 0;
    int failures  = 0;
    int ecnt      = 0;
    int busy_lo   = 1;
    int busy_hi   = 0;
    int idle_from = 32'h3fff_ffff;

    always @(posedge clk) ecnt <= ecnt + 1;

    function automatic void check(string name, int got, int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, ecnt, got, exp);
        end
    endfunction

    function automatic void report(string name, int got, int exp);
        checks++;
        failures++;
        $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, ecnt, got, exp);
    endfunction

    // Drop every scheduled event later than cycle c (frame cancelled at c).
    function automatic void purge(int c);
        while (tick_q.size() > 0 && tick_q[$].cyc > c) void'(tick_q.pop_back());
        while (tiempo_q.size() > 0 && tiempo_q[$].cyc > c) void'(tiempo_q.pop_back());
        while (mid_q.size() > 0 && mid_q[$].cyc > c) void'(mid_q.pop_back());
    endfunction

    // Present inputs for one cycle and update the reference schedule.
    task automatic drive(input bit st, input bit ab, input int nb, input int dv);
        int c;
        int d;
        @(negedge clk);
        c = ecnt;
        bus.start  = st;
        bus.abort  = ab;
        bus.n_bits = CNT_W'(nb);
        bus.div    = DIV_W'(dv);
        if (ab) begin
            if (c >= busy_lo && c <= busy_hi) begin
                purge(c);
                busy_hi   = c;
                idle_from = c + 1;
            end
        end else if (st && c >= idle_from) begin
            d = (dv == 0) ? 1 : dv;
            for (int k = 1; k <= nb; k++) begin
                tick_q.push_back('{c + k * d, k - 1});
                mid_q.push_back('{c + (k - 1) * d + 1 + (d - 1) / 2, 0});
            end
            tiempo_q.push_back('{c + nb * d + 1, nb});
            busy_lo   = c + 1;
            busy_hi   = c + nb * d;
            idle_from = c + nb * d + 2;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 0);
    endtask

    // Monitor
    always @(negedge clk) begin
        ev_t ev;
        while (tick_q.size() > 0 && tick_q[0].cyc < ecnt) begin
            ev = tick_q.pop_front();
            report("tick_missing", 0, ev.cyc);
        end
        while (tiempo_q.size() > 0 && tiempo_q[0].cyc < ecnt) begin
            ev = tiempo_q.pop_front();
            report("tiempo_missing", 0, ev.cyc);
        end
        if (bus.tick) begin
            if (tick_q.size() == 0) report("tick_unexpected", 1, 0);
            else begin
                ev = tick_q.pop_front();
                check("tick_cycle", ecnt, ev.cyc);
                check("tick_bit_idx", int'(bus.bit_idx), ev.idx);
            end
        end
        if (bus.tiempo) begin
            if (tiempo_q.size() == 0) report("tiempo_unexpected", 1, 0);
            else begin
                ev = tiempo_q.pop_front();
                check("tiempo_cycle", ecnt, ev.cyc);
                check("tiempo_bit_idx", int'(bus.bit_idx), ev.idx);
            end
        end
`ifdef CB_MID_TICK_EN
        while (mid_q.size() > 0 && mid_q[0].cyc < ecnt) begin
            ev = mid_q.pop_front();
            report("mid_missing", 0, ev.cyc);
        end
        if (bus.mid) begin
            if (mid_q.size() == 0) report("mid_unexpected", 1, 0);
            else begin
                ev = mid_q.pop_front();
                check("mid_cycle", ecnt, ev.cyc);
            end
        end
`else
        while (mid_q.size() > 0 && mid_q[0].cyc <= ecnt) void'(mid_q.pop_front());
`endif
        check("busy", int'(bus.busy), (ecnt >= busy_lo && ecnt <= busy_hi) ? 1 : 0);
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", ecnt);
        $fatal(1);
    end

    initial begin
        int c;
        int nb;
        int dv;
        int len;
        int ab_at;
        bus.start  = 1'b0;
        bus.abort  = 1'b0;
        bus.n_bits = '0;
        bus.div    = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_tick", int'(bus.tick), 0);
        check("reset_tiempo", int'(bus.tiempo), 0);
        check("reset_bit_idx", int'(bus.bit_idx), 0);
`ifdef CB_MID_TICK_EN
        check("reset_mid", int'(bus.mid), 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        idle_from = ecnt;

        // 8 bits, div 4
        drive(1'b1, 1'b0, 8, 4);
        idle(40);
        check("bit_idx_hold_8", int'(bus.bit_idx), 8);

        // div 0 behaves as div 1
        drive(1'b1, 1'b0, 11, 0);
        idle(15);
        check("bit_idx_hold_11", int'(bus.bit_idx), 11);

        // zero-length frame
        drive(1'b1, 1'b0, 0, 3);
        idle(4);
        check("bit_idx_zero_frame", int'(bus.bit_idx), 0);

        // abort in cycle 14 with a coincident start
        drive(1'b1, 1'b0, 8, 4);
        idle(13);
        drive(1'b1, 1'b1, 5, 2);
        drive(1'b0, 1'b0, 0, 0);
        check("abort_bit_idx", int'(bus.bit_idx), 3);
        check("abort_tiempo", int'(bus.tiempo), 0);
        idle(10);
        check("abort_bit_idx_frozen", int'(bus.bit_idx), 3);

        // 2-cycle reset in mid-frame
        drive(1'b1, 1'b0, 10, 3);
        idle(7);
        @(negedge clk);
        rst = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        c = ecnt;
        purge(c);
        busy_hi   = c;
        idle_from = c + 2;
        @(negedge clk);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_bit_idx", int'(bus.bit_idx), 0);
        check("rst_tiempo", int'(bus.tiempo), 0);
        @(negedge clk);
        rst = 1'b0;
        idle(40);

        // random frames with stray starts and occasional aborts
        for (int it = 0; it < 30; it++) begin
            nb    = ($urandom % 8 == 0) ? 31 : int'($urandom_range(0, 12));
            dv    = int'($urandom_range(0, 4));
            len   = nb * ((dv == 0) ? 1 : dv) + 3;
            ab_at = ($urandom % 3 == 0) ? int'($urandom_range(1, len)) : -1;
            drive(1'b1, 1'b0, nb, dv);
            for (int j = 1; j <= len; j++) begin
                drive($urandom % 5 == 0, j == ab_at, int'($urandom_range(0, 12)),
                      int'($urandom_range(0, 4)));
            end
        end

        idle(200);
        check("pending_tick", tick_q.size(), 0);
        check("pending_tiempo", tiempo_q.size(), 0);
`ifdef CB_MID_TICK_EN
        check("pending_mid", mid_q.size(), 0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
